// File: rtl/ro_trng_core.sv
// Ring-oscillator entropy core: sync, tick sampling, XOR, von Neumann debias, word packing.
// Build option: define TRNG_HEALTH_TEST_EN to add the repetition-count health test on raw bits.
module ro_trng_core #(
    parameter int NUM_RO         = 4,
    parameter int RO_LENGTH      = 13,
    parameter int RO_LENGTH_STEP = 2,
    parameter int WORD_WIDTH     = 32,
    parameter int SAMPLE_DIV     = 8,
    parameter int WARMUP_CYCLES  = 64,
    parameter int RCT_CUTOFF     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  dropped_o,
    output logic                  alarm_o
);
    // state  | meaning
    // IDLE   | rings stopped, datapath flushed, output word held until drained
    // WARMUP | rings running, sampling held off for WARMUP_CYCLES cycles
    // RUN    | sampling on each tick, debiasing and packing words
    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

    localparam int RO_MAX = RO_LENGTH + (NUM_RO - 1) * RO_LENGTH_STEP;
    localparam int RW     = $clog2(RO_MAX);
    localparam int CW     = $clog2(WORD_WIDTH + 1);
    localparam int SW     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int UW     = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [CW-1:0] WORD_FULL = CW'(WORD_WIDTH);
    localparam logic [SW-1:0] SMP_LAST  = SW'(SAMPLE_DIV - 1);
    localparam logic [UW-1:0] WU_LOAD   = UW'(WARMUP_CYCLES - 1);

    state_t            state;
    logic [UW-1:0]     wu_cnt;
    logic              ro_stop;
    logic [NUM_RO-1:0] ro_bits;
    logic [NUM_RO-1:0] ro_q;
    logic [RW-1:0]     ro_dly [NUM_RO];
    logic [NUM_RO-1:0] sync1, sync2;

    assign ro_stop = (state == IDLE);

    // Clocked stand-in for the inverter rings; the hard ring macros drive ro_bits at integration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ro_q <= '0;
            for (int k = 0; k < NUM_RO; k++) ro_dly[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_RO; k++) begin
                if (ro_stop || ro_dly[k] == '0)
                    ro_dly[k] <= RW'(RO_LENGTH + k * RO_LENGTH_STEP - 1);
                else
                    ro_dly[k] <= ro_dly[k] - RW'(1);
                if (!ro_stop && ro_dly[k] == '0) ro_q[k] <= ~ro_q[k];
            end
        end
    end

    assign ro_bits = ro_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ro_bits;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            wu_cnt <= '0;
            busy_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable_i) begin
                    state  <= WARMUP;
                    wu_cnt <= WU_LOAD;
                    busy_o <= 1'b1;
                end
                WARMUP: if (!enable_i) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end else if (wu_cnt == '0) begin
                    state <= RUN;
                end else begin
                    wu_cnt <= wu_cnt - UW'(1);
                end
                RUN: if (!enable_i) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    logic [SW-1:0]         smp_cnt;
    logic                  tick;
    logic                  raw_vld, raw_q;
    logic                  pair_have, pair_first;
    logic                  db_vld, db_bit;
    logic [WORD_WIDTH-1:0] acc;
    logic [CW-1:0]         bit_cnt;
    logic                  word_full;

    assign tick      = (state == RUN) && (smp_cnt == SMP_LAST);
    assign word_full = (bit_cnt == WORD_FULL);

`ifdef TRNG_HEALTH_TEST_EN
    localparam int RCW = $clog2(RCT_CUTOFF + 1);
    localparam logic [RCW-1:0] RCT_LIMIT = RCW'(RCT_CUTOFF);

    logic [RCW-1:0] rct_cnt;
    logic           rct_last;
    logic           alarm_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rct_cnt  <= '0;
            rct_last <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            if (rct_cnt == RCT_LIMIT) alarm_q <= 1'b1;
            if (state == IDLE) begin
                rct_cnt <= '0;
            end else if (raw_vld) begin
                rct_last <= raw_q;
                if (rct_cnt == '0 || raw_q != rct_last) rct_cnt <= RCW'(1);
                else if (rct_cnt != RCT_LIMIT)          rct_cnt <= rct_cnt + RCW'(1);
            end
        end
    end

    assign alarm_o = alarm_q;
`else
    assign alarm_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            smp_cnt    <= '0;
            raw_vld    <= 1'b0;
            raw_q      <= 1'b0;
            pair_have  <= 1'b0;
            pair_first <= 1'b0;
            db_vld     <= 1'b0;
            db_bit     <= 1'b0;
            acc        <= '0;
            bit_cnt    <= '0;
        end else if (state == IDLE) begin
            smp_cnt   <= '0;
            raw_vld   <= 1'b0;
            pair_have <= 1'b0;
            db_vld    <= 1'b0;
            acc       <= '0;
            bit_cnt   <= '0;
        end else begin
            if (state == RUN) smp_cnt <= tick ? '0 : smp_cnt + SW'(1);
            raw_vld <= tick;
            if (tick) raw_q <= ^sync2;

            // Pair (first, second): 10 emits 1, 01 emits 0, equal pairs are discarded.
            db_vld <= 1'b0;
            if (raw_vld) begin
                if (!pair_have) begin
                    pair_have  <= 1'b1;
                    pair_first <= raw_q;
                end else begin
                    pair_have <= 1'b0;
                    db_vld    <= (pair_first != raw_q);
                    db_bit    <= pair_first;
                end
            end

            if (alarm_o) begin
                acc     <= '0;
                bit_cnt <= '0;
            end else if (word_full) begin
                acc     <= db_vld ? WORD_WIDTH'(db_bit) : '0;
                bit_cnt <= db_vld ? CW'(1) : '0;
            end else if (db_vld) begin
                acc     <= acc | (WORD_WIDTH'(db_bit) << bit_cnt);
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            dropped_o <= 1'b0;
        end else begin
            if (valid_o && ready_i) valid_o <= 1'b0;
            if (word_full && state != IDLE && !alarm_o) begin
                if (!valid_o || ready_i) begin
                    data_o  <= acc;
                    valid_o <= 1'b1;
                end else begin
                    dropped_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ro_trng_core.sv
// Scoreboard bench for ro_trng_core: forces ro_bits with planned raw sequences, checks words and flags.
module tb_ro_trng_core;
    localparam int WW = 8;
`ifdef TRNG_HEALTH_TEST_EN
    localparam bit EXP_ALARM = 1'b1;
    localparam int EXP_HEALTH_WORDS = 0;
`else
    localparam bit EXP_ALARM = 1'b0;
    localparam int EXP_HEALTH_WORDS = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          enable_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [WW-1:0] data_o;
    logic          valid_o, busy_o, dropped_o, alarm_o;

    int            total = 0;
    int            bad = 0;
    int            words_seen = 0;
    logic [WW-1:0] exp_q[$];
    bit            raw_src[$];
    bit            drv_on = 1'b0;
    int            drv_j = 0;
    logic [3:0]    ro_val = '0;

    always #5 clk = ~clk;

    ro_trng_core #(
        .NUM_RO(4), .RO_LENGTH(13), .RO_LENGTH_STEP(2), .WORD_WIDTH(WW),
        .SAMPLE_DIV(1), .WARMUP_CYCLES(4), .RCT_CUTOFF(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
        .dropped_o(dropped_o), .alarm_o(alarm_o)
    );

    // Value for edge E_j (E_0 = first edge with enable high) feeds raw tick j-3 through the 2-flop sync.
    always @(posedge clk) begin
        #2;
        if (drv_on) begin
            bit rb;
            int i;
            drv_j++;
            i  = drv_j - 3;
            rb = 1'b0;
            if (drv_j >= 3) begin
                if (raw_src.size() > 0) rb = raw_src.pop_front();
                else rb = ((i / 2) % 2) != 0;
            end
            ro_val = 4'($urandom_range(0, 15));
            if ((^ro_val) != rb) ro_val[0] = ~ro_val[0];
            force dut.ro_bits = ro_val;
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_ni && valid_o && ready_i) begin
            words_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_word: got unexpected data_o=%h, no word expected", data_o);
            end else begin
                logic [WW-1:0] e;
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    bad++;
                    $display("FAIL sb_word: data_o=%h required %h", data_o, e);
                end
            end
        end
    end

    task automatic push_pair(input bit a, input bit b);
        raw_src.push_back(a);
        raw_src.push_back(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0; enable_i = 1'b0; ready_i = 1'b0; drv_on = 1'b0;
        raw_src.delete(); exp_q.delete();
        ro_val = '0; force dut.ro_bits = ro_val;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_run();
        @(negedge clk);
        drv_j = 0; drv_on = 1'b1;
        ro_val = '0; force dut.ro_bits = ro_val;
        enable_i = 1'b1;
    endtask

    task automatic stop_run();
        @(negedge clk);
        enable_i = 1'b0; drv_on = 1'b0; raw_src.delete();
        ro_val = '0; force dut.ro_bits = ro_val;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (valid_o === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_sb_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d words still pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; enable_i = 1'b0; ready_i = 1'b0;
        ro_val = '0; force dut.ro_bits = ro_val;
        repeat (3) @(negedge clk);
        for (int ph = 0; ph < 2; ph++) begin
            total += 5;
            if (data_o !== '0)     begin bad++; $display("FAIL reset_data ph%0d: %h required 00", ph, data_o); end
            if (valid_o !== 1'b0)  begin bad++; $display("FAIL reset_valid ph%0d: %b required 0", ph, valid_o); end
            if (busy_o !== 1'b0)   begin bad++; $display("FAIL reset_busy ph%0d: %b required 0", ph, busy_o); end
            if (dropped_o !== 1'b0) begin bad++; $display("FAIL reset_dropped ph%0d: %b required 0", ph, dropped_o); end
            if (alarm_o !== 1'b0)  begin bad++; $display("FAIL reset_alarm ph%0d: %b required 0", ph, alarm_o); end
            if (ph == 0) begin
                rst_ni = 1'b1;
                repeat (5) @(negedge clk);
            end
        end
    endtask

    task automatic test_warmup();
        int cyc = 0;
        bit seen = 1'b0;
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) push_pair(1'b0, 1'b1);
        exp_q.push_back(8'h00);
        start_run();
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                total++;
                if (busy_o !== 1'b1) begin bad++; $display("FAIL busy_rise: busy_o=%b required 1", busy_o); end
            end
            if (valid_o === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || cyc < 23) begin
            bad++;
            $display("FAIL first_valid: seen=%b after %0d cycles, required seen after >=23", seen, cyc);
        end
        @(negedge clk);
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL valid_fall: valid_o=%b required 0", valid_o); end
        wait_sb_empty("warmup");
        stop_run();
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL busy_fall: busy_o=%b required 0", busy_o); end
    endtask

    task automatic test_debias();
        bit ok;
        int w0;
        do_reset();
        ready_i = 1'b1;
        w0 = words_seen;
        push_pair(1,0); push_pair(0,1); push_pair(1,1); push_pair(0,0); push_pair(1,0);
        push_pair(1,0); push_pair(0,1); push_pair(0,1); push_pair(1,0); push_pair(0,1);
        exp_q.push_back(8'h4D);
        start_run();
        wait_valid(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL debias_valid: valid_o never rose, required 1"); end
        wait_sb_empty("debias");
        repeat (30) @(negedge clk);
        total++;
        if (words_seen - w0 != 1) begin
            bad++;
            $display("FAIL debias_count: %0d words, required 1", words_seen - w0);
        end
        stop_run();
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit stable = 1'b1;
        do_reset();
        ready_i = 1'b0;
        push_pair(1,0); push_pair(0,1); push_pair(1,1); push_pair(0,0); push_pair(1,0);
        push_pair(1,0); push_pair(0,1); push_pair(0,1); push_pair(1,0); push_pair(0,1);
        for (int i = 0; i < 8; i++) push_pair(1'b1, 1'b0);
        exp_q.push_back(8'h4D);
        start_run();
        wait_valid(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_valid: valid_o never rose, required 1"); end
        repeat (40) begin
            @(negedge clk);
            if (valid_o !== 1'b1 || data_o !== 8'h4D) stable = 1'b0;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_hold: data_o=%h valid_o=%b, required 4d held with valid 1", data_o, valid_o);
        end
        total++;
        if (dropped_o !== 1'b1) begin bad++; $display("FAIL bp_dropped: dropped_o=%b required 1", dropped_o); end
        @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL bp_valid_fall: valid_o=%b required 0", valid_o); end
        wait_sb_empty("bp");
        repeat (10) @(negedge clk);
        total++;
        if (dropped_o !== 1'b1) begin bad++; $display("FAIL bp_dropped_sticky: dropped_o=%b required 1", dropped_o); end
        stop_run();
    endtask

    task automatic test_midrun_disable();
        bit ok;
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) push_pair(1'b1, 1'b0);
        start_run();
        repeat (20) @(negedge clk);
        stop_run();
        @(negedge clk);
        total += 2;
        if (busy_o !== 1'b0)  begin bad++; $display("FAIL md_busy: busy_o=%b required 0", busy_o); end
        if (valid_o !== 1'b0) begin bad++; $display("FAIL md_valid: valid_o=%b required 0", valid_o); end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) push_pair(1'b0, 1'b1);
        exp_q.push_back(8'h00);
        start_run();
        wait_valid(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL md_reenable_valid: valid_o never rose, required 1"); end
        wait_sb_empty("md");
        stop_run();
    endtask

    task automatic test_health();
        int w0;
        do_reset();
        ready_i = 1'b1;
        w0 = words_seen;
        for (int i = 0; i < 10; i++) push_pair(1'b1, 1'b1);
        for (int i = 0; i < 8; i++)  push_pair(1'b0, 1'b1);
        if (EXP_HEALTH_WORDS == 1) exp_q.push_back(8'h00);
        start_run();
        repeat (80) @(negedge clk);
        total += 2;
        if (alarm_o !== EXP_ALARM) begin
            bad++; $display("FAIL health_alarm: alarm_o=%b required %b", alarm_o, EXP_ALARM);
        end
        if (words_seen - w0 != EXP_HEALTH_WORDS) begin
            bad++; $display("FAIL health_words: %0d words, required %0d", words_seen - w0, EXP_HEALTH_WORDS);
        end
        wait_sb_empty("health");
        stop_run();
        repeat (3) @(negedge clk);
        total++;
        if (alarm_o !== EXP_ALARM) begin
            bad++; $display("FAIL health_sticky: alarm_o=%b required %b", alarm_o, EXP_ALARM);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_warmup();
        test_debias();
        test_back_to_back();
        test_midrun_disable();
        test_health();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ro_trng_core.md
Name: ro_trng_core

Overview:
- Parametrised multi-ring entropy source: NUM_RO free-running inverter rings of staggered lengths.
- Ring outputs are synchronised, sampled on a divided tick, XOR-combined, von-Neumann debiased and packed into WORD_WIDTH words.
- Words are delivered over a valid/ready interface.
- Sits between the ring primitives and the TRNG register/bus wrapper.

Parameters:
- NUM_RO, 4, number of rings (>=1).
- RO_LENGTH, 13, inverter count of ring 0 (odd, >=3).
- RO_LENGTH_STEP, 2, length increment per ring; ring k has RO_LENGTH + k*RO_LENGTH_STEP inverters (even, so every length stays odd).
- WORD_WIDTH, 32, output word width (>=2).
- SAMPLE_DIV, 8, clock cycles per sample tick (>=1).
- WARMUP_CYCLES, 64, cycles the rings run before sampling starts (>=1).
- RCT_CUTOFF, 16, repetition-count cutoff; used only with TRNG_HEALTH_TEST_EN.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- enable_i  input  1  1 = run the source; 0 = stop the rings and flush
- data_o  output  WORD_WIDTH  random word; bit 0 = first debiased bit
- valid_o  output  1  data_o holds a word
- ready_i  input  1  consumer accepts the word
- busy_o  output  1  FSM not in IDLE
- dropped_o  output  1  sticky: a completed word was discarded
- alarm_o  output  1  sticky health alarm (0 when feature compiled out)

Behaviour:
- Reset (async, rst_ni=0): FSM=IDLE; all outputs 0; accumulator, bit count, pair register, sample counter, synchronisers, dropped/alarm cleared.
- Ring stop: internal net ro_stop=1 in IDLE holds every ring static; 0 otherwise. Ring outputs form net ro_bits[NUM_RO-1:0]; the bench may force this net.
- Synchroniser: each ro_bits[k] passes a 2-flop synchroniser clocked by clk_i.
- FSM:
  - IDLE -> WARMUP when enable_i=1.
  - WARMUP counts WARMUP_CYCLES cycles, then -> RUN.
  - Any state -> IDLE the cycle after enable_i=0.
  - Entering IDLE clears accumulator, bit count, pair register and sample counter. An already valid output word is kept until accepted. dropped_o and alarm_o are kept.
- Sample tick (RUN only): counter runs 0..SAMPLE_DIV-1; tick fires when count=SAMPLE_DIV-1, then wraps to 0. raw = XOR of the synchronised bits at the tick.
- Von Neumann:
  - Raw bits form non-overlapping pairs (first, second).
  - 01 -> emit 0; 10 -> emit 1; 00/11 -> discard.
  - At most one debiased bit per two ticks.
- Packing:
  - Each debiased bit is written at index bit_cnt; bit_cnt increments.
  - When bit_cnt reaches WORD_WIDTH: the word moves to the output register if it is empty, or is being accepted (valid_o & ready_i) in the same cycle. valid_o=1 from the next cycle. bit_cnt returns to 0.
  - Otherwise the word is discarded, dropped_o is set, and bit_cnt returns to 0.
- Handshake:
  - data_o is stable while valid_o=1 & ready_i=0.
  - valid_o falls the cycle after valid_o & ready_i, unless a new word loads in that same cycle (back-to-back).
  - ready_i with valid_o=0 has no effect.
- dropped_o clears only on reset.
- Latency: at least WARMUP_CYCLES + 2*WORD_WIDTH*SAMPLE_DIV + 3 cycles from enable_i rising to the first valid_o.

Optional Feature:
- Macro: TRNG_HEALTH_TEST_EN.
- Defined: repetition-count test on raw bits during RUN. A run counter counts consecutive identical raw bits; it resets to 1 on each change.
- When the counter reaches RCT_CUTOFF, alarm_o=1 (sticky until reset).
- While alarm_o=1: no debiased bits are accepted, the partial word is cleared, and the current output word may still be drained.
- Not defined: alarm_o tied 0; no test logic.

Test Plan:
- Reset: hold rst_ni=0 -> data_o=0, valid_o=0, busy_o=0, dropped_o=0, alarm_o=0; release with enable_i=0 -> all stay 0.
- Warm-up timing: WORD_WIDTH=8, SAMPLE_DIV=1, WARMUP_CYCLES=4; force ro_bits so raw alternates 0,1 per tick -> every pair is 01, emitting 0; busy_o=1 one cycle after enable_i; first valid_o with data_o=8'h00 no earlier than 4+16+3 cycles.
- Debias: force raw sequence 10,01,11,00,10,10,01,01,10,01 -> emitted bits 1,0,1,1,0,0,1,0 -> data_o=8'h4D; discarded pairs produce no bit.
- Back-pressure and drop: hold ready_i=0 over two completed words -> first word stable on data_o; second word discarded; dropped_o=1; pulsing ready_i once -> valid_o=0 next cycle.
- Mid-run disable: deassert enable_i after 5 debiased bits -> IDLE next cycle; busy_o=0; re-enable -> next word contains only new bits.
- TRNG_HEALTH_TEST_EN, RCT_CUTOFF=16: force raw=1 for 16 ticks -> alarm_o=1; no further valid_o. Without the macro, same stimulus -> alarm_o stays 0 (and no words are produced, since every pair is 11).
